mazesolver_soc_key_pio: RTL

MAZESOLVER_SOC_KEY_PIO -- requirements
Module: mazesolver_soc_key_pio

---
 rtl/mazesolver_soc_pio_pkg.sv | 32 +++
 rtl/mazesolver_soc_key_debounce.sv | 65 ++++++
 rtl/mazesolver_soc_key_pio.sv | 96 +++++++++
 3 files changed

// File: rtl/mazesolver_soc_pio_pkg.sv
// Purpose : shared register offsets, edge-type encodings and edge-select helper for the key PIO.
// Latency : n/a (constants and a pure function only).
// Backpr. : n/a.
package mazesolver_soc_pio_pkg;

  // Avalon-MM word offsets of the key PIO register file.
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,  // debounced key levels, read-only
    REG_RSVD    = 2'd1,  // reserved, reads 0
    REG_IRQMASK = 2'd2,  // interrupt enable per key, R/W
    REG_EDGECAP = 2'd3   // captured edges, write-1-to-clear
  } reg_addr_e;

  // EDGE_TYPE parameter encodings.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Selects which debounced transitions count as an edge event.
  function automatic logic edge_match(input int kind, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (kind)
      EDGE_RISING:  hit = rise;
      EDGE_FALLING: hit = fall;
      EDGE_ANY:     hit = rise | fall;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mazesolver_soc_key_debounce.sv
// Purpose : one key channel: 2-flop synchroniser followed by a stable-count debouncer.
// Latency : 2 sync cycles + DEBOUNCE_CYCLES stable cycles before level follows key_in.
// Backpr. : none; free-running, no handshake.
// Ports   : clk, reset_n (sync, active-low); key_in (async raw key);
//           level (debounced), rise/fall (one-cycle pulses, asserted the cycle before level flips).
module mazesolver_soc_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // One spare bit above clog2 so the terminal value always fits; the count
  // clears on accept, so it never wraps.
  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    accept  = 1'b0;
    // Any cycle where the levels agree resets the count, so short glitches
    // never accumulate towards an accept.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset to the released (high) level everywhere so no edge follows reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = accept &  sync2_q;
  assign fall  = accept & ~sync2_q;

endmodule

// File: rtl/mazesolver_soc_key_pio.sv
// Purpose : debounced key PIO with Avalon-MM register file (data/irqmask/edgecapture) and level irq.
// Latency : readdata 1 cycle after address; irq 1 cycle after edgecapture/irqmask change.
// Backpr. : none; slave has no waitrequest, every access completes in one cycle.
// Ports   : clk, reset_n (sync, active-low); address/chipselect/write_n/writedata/readdata (Avalon-MM);
//           in_port (raw async keys); irq (active-high level).
module mazesolver_soc_key_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  import mazesolver_soc_pio_pkg::*;

  logic [WIDTH-1:0] level, rise, fall, evt, clr;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    mazesolver_soc_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .key_in (in_port[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Writedata bits above WIDTH have no storage behind them.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      evt[i] = edge_match(EDGE_TYPE, rise[i], fall[i]);
    end

    irqmask_d = irqmask_q;
    if (wr_en && (address == REG_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end

    clr = '0;
    if (wr_en && (address == REG_EDGECAP)) begin
      clr = writedata[WIDTH-1:0];
    end
    // Set is OR-ed in after the clear so a coincident event is never lost.
    edgecap_d = (edgecap_q & ~clr) | evt;

    irq_d = |(edgecap_q & irqmask_q);

    readdata_d = '0;
    case (address)
      REG_DATA:    readdata_d[WIDTH-1:0] = level;
      REG_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      REG_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
